// File: rtl/rng_range_sampler.sv
// rng_range_sampler: turns raw 8-bit maximal-LFSR bytes into a uniform value
// in [0, N) using rejection sampling. The number of draws per request is
// bounded, and results are handed off with a valid/ready handshake. The
// sampler owns the LFSR advance enable, so the LFSR steps only when a byte is
// actually consumed.
// Optional build macro RNG_SAMPLER_STATS_EN adds a saturating count of
// rejected draws (reject_count).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; N is latched when start is accepted
// SETUP  | 8-step division 255 / N, which gives limit = 255 - (255 mod N)
// DRAW   | one LFSR byte per cycle until a sample is below limit, or the
//        | last permitted draw is reached (that draw is forced to accept)
// REDUCE | 8-step division sample / N; the remainder becomes the result
// DONE   | result presented (valid), waiting for ready

module rng_range_sampler #(
    parameter int unsigned MAX_DRAWS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] range_n,
    input  logic [7:0] lfsr_q,
    output logic       lfsr_en,
    output logic [7:0] result,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       biased
`ifdef RNG_SAMPLER_STATS_EN
    ,
    output logic [15:0] reject_count
`endif
);

    localparam logic [7:0] MAX_DRAWS_B = 8'(MAX_DRAWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_DRAW,
        S_REDUCE,
        S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] n_q;
    logic [7:0] limit_q;
    logic [7:0] dvd_q;
    logic [7:0] rem_q;
    logic [7:0] sample_q;
    logic [7:0] draws_q;
    logic [2:0] step_q;

    logic [7:0] sample;
    logic [8:0] rem_shift;
    logic [7:0] rem_next;
    logic [7:0] draws_inc;
    logic       accept;
    logic       handshake;

    // Shared restoring-division step, the current draw, and the accept decision.
    // After a subtract the remainder is below N, so 8 bits are enough to hold it.
    // Only the shifted value needs the ninth bit.
    always_comb begin
        sample    = lfsr_q - 8'd1;
        rem_shift = {rem_q, dvd_q[7]};
        if (rem_shift >= {1'b0, n_q}) begin
            rem_next = 8'(rem_shift - {1'b0, n_q});
        end else begin
            rem_next = rem_shift[7:0];
        end
        draws_inc = draws_q + 8'd1;
        accept    = (sample < limit_q) || (draws_inc == MAX_DRAWS_B);
        handshake = valid && ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the decoded outputs lfsr_en and busy.
    always_comb begin
        state_nxt = state;
        lfsr_en   = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETUP;
            S_SETUP:  if (step_q == 3'd7) state_nxt = S_DRAW;
            S_DRAW: begin
                lfsr_en = 1'b1;
                if (accept) state_nxt = S_REDUCE;
            end
            S_REDUCE: if (step_q == 3'd7) state_nxt = S_DONE;
            S_DONE:   if (handshake) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch N, both divisions, draw counting, and the result registers.
    // valid is registered and rises one cycle after DONE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q      <= '0;
            limit_q  <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            sample_q <= '0;
            draws_q  <= '0;
            step_q   <= '0;
            result   <= '0;
            biased   <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= (state == S_DONE) && !handshake;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q     <= range_n;
                        draws_q <= '0;
                        rem_q   <= '0;
                        dvd_q   <= 8'hFF;
                        step_q  <= '0;
                    end
                end
                S_SETUP: begin
                    rem_q  <= rem_next;
                    dvd_q  <= {dvd_q[6:0], 1'b0};
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        limit_q <= (n_q == 8'd0) ? 8'hFF : 8'hFF - rem_next;
                    end
                end
                S_DRAW: begin
                    draws_q <= draws_inc;
                    if (accept) begin
                        sample_q <= sample;
                        biased   <= (sample >= limit_q);
                        rem_q    <= '0;
                        dvd_q    <= sample;
                        step_q   <= '0;
                    end
                end
                S_REDUCE: begin
                    rem_q  <= rem_next;
                    dvd_q  <= {dvd_q[6:0], 1'b0};
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        result <= (n_q == 8'd0) ? sample_q : rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RNG_SAMPLER_STATS_EN
    // Saturating count of rejected draws. A forced final accept is not a reject.
    always_ff @(posedge clk) begin
        if (rst) begin
            reject_count <= '0;
        end else if ((state == S_DRAW) && !accept && (reject_count != 16'hFFFF)) begin
            reject_count <= reject_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rng_range_sampler.sv
// Scoreboard bench for rng_range_sampler. The driver issues requests and pushes
// reference results, computed with plain arithmetic, into a queue. A monitor
// pops an entry each time valid rises and compares it against the DUT.
module tb_rng_range_sampler;

    localparam int MAXD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] range_n;
    logic [7:0] lfsr_q;
    logic       lfsr_en;
    logic [7:0] result;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       biased;
`ifdef RNG_SAMPLER_STATS_EN
    logic [15:0] reject_count;
`endif

    rng_range_sampler #(.MAX_DRAWS(MAXD)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .range_n (range_n),
        .lfsr_q  (lfsr_q),
        .lfsr_en (lfsr_en),
        .result  (result),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .biased  (biased)
`ifdef RNG_SAMPLER_STATS_EN
        ,
        .reject_count (reject_count)
`endif
    );

    always #5 clk = ~clk;

    int e = 0;
    always @(posedge clk) e <= e + 1;

    typedef struct {
        logic [7:0] res;
        logic       bias;
        int         nd;
        int         start_e;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] vals [0:15];
    int         vidx = 0;
    int         draws_seen = 0;
    logic       prev_valid = 1'b0;
    int         exp_rej = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: take bytes in order; the first sample below the limit
    // wins, otherwise the last permitted draw is taken as a biased result.
    task automatic model(input int n, output logic [7:0] res, output logic bias, output int nd);
        int lim;
        int s;
        lim  = (n == 0) ? 255 : 255 - (255 % n);
        res  = 8'd0;
        bias = 1'b0;
        nd   = MAXD;
        for (int k = 0; k < MAXD; k++) begin
            s = (int'(vals[k]) + 255) % 256;
            if (s < lim || k == MAXD - 1) begin
                nd   = k + 1;
                bias = (s >= lim);
                res  = (n == 0) ? 8'(s) : 8'(s % n);
                return;
            end
        end
    endtask

    // LFSR stand-in: present vals[vidx], and move to the next byte after each
    // cycle in which lfsr_en was high.
    initial begin
        logic en_now;
        forever begin
            @(negedge clk);
            en_now = lfsr_en;
            @(posedge clk);
            #1;
            if (en_now && vidx < 15) vidx++;
            lfsr_q = vals[vidx];
        end
    end

    // Monitor: check latency, draw count, result and bias when valid rises.
    // While valid is held, check that the result stays stable.
    always @(negedge clk) begin
        if (rst) begin
            draws_seen = 0;
            prev_valid = 1'b0;
        end else begin
            if (lfsr_en) draws_seen++;
            if (lfsr_en && !busy) chk("lfsr_en_while_idle", 1, 0);
            if (valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    chk("result", int'(result), int'(cur.res));
                    chk("biased", int'(biased), int'(cur.bias));
                    chk("latency", e - cur.start_e, 17 + cur.nd);
                    chk("draws", draws_seen, cur.nd);
                end
                draws_seen = 0;
            end else if (valid) begin
                chk("result_stable", int'(result), int'(cur.res));
                chk("lfsr_en_in_done", int'(lfsr_en), 0);
            end
            prev_valid = valid;
        end
    end

    task automatic issue(input logic [7:0] n, input bit push);
        exp_t x;
        model(int'(n), x.res, x.bias, x.nd);
        @(negedge clk);
        vidx    = 0;
        lfsr_q  = vals[0];
        range_n = n;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        range_n   = 8'($urandom);
        x.start_e = e;
        if (push) begin
            sb.push_back(x);
            exp_rej = exp_rej + x.nd - 1;
            if (exp_rej > 65535) exp_rej = 65535;
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (valid) return;
        end
        chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic check_stats();
`ifdef RNG_SAMPLER_STATS_EN
        chk("reject_count", int'(reject_count), exp_rej);
`endif
    endtask

    task automatic finish_req(input int d);
        if (!ready) begin
            repeat (d) @(posedge clk);
            @(negedge clk);
            ready = 1'b1;
        end
        @(posedge clk);
        #2;
        chk("valid_drop", int'(valid), 0);
        chk("busy_drop", int'(busy), 0);
        check_stats();
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) vals[i] = v;
    endtask

    task automatic check_reset_outputs();
        chk("rst_lfsr_en", int'(lfsr_en), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_biased", int'(biased), 0);
        chk("rst_result", int'(result), 0);
        check_stats();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] n;
        int r;
        fill(8'h01);
        lfsr_q  = 8'h01;
        rst     = 1'b1;
        start   = 1'b0;
        ready   = 1'b1;
        range_n = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Plain accept
        fill(8'h01);
        issue(8'd10, 1'b1); wait_valid(); finish_req(0);
        // Single reject
        fill(8'h2A); vals[0] = 8'hFB;
        issue(8'd10, 1'b1); wait_valid(); finish_req(0);
        // Forced accept on the last permitted draw
        fill(8'hFF);
        issue(8'd10, 1'b1); wait_valid(); finish_req(0);
        // Full range
        fill(8'hC8);
        issue(8'd0, 1'b1); wait_valid(); finish_req(0);

        // Reset while in REDUCE abandons the request
        fill(8'h05);
        issue(8'd9, 1'b0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_rej = 0;
        check_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fill(8'h10);
        issue(8'd6, 1'b1); wait_valid(); finish_req(0);

        // N = 1
        fill(8'hFF);
        issue(8'd1, 1'b1); wait_valid(); finish_req(0);

        // Backpressure; a start pulse during DONE and one on the handshake edge are both ignored
        @(negedge clk);
        ready = 1'b0;
        fill(8'h33);
        issue(8'd7, 1'b1);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start   = (i == 5);
            range_n = 8'd3;
            @(posedge clk);
            #2;
            chk("bp_valid", int'(valid), 1);
            chk("bp_busy", int'(busy), 1);
            chk("bp_lfsr_en", int'(lfsr_en), 0);
        end
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        chk("bp_valid_drop", int'(valid), 0);
        chk("bp_busy_drop", int'(busy), 0);
        @(posedge clk);
        #2;
        chk("start_in_done_ignored", int'(busy), 0);
        check_stats();

        // Randomized requests
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 16; i++) begin
                r = $urandom_range(0, 15);
                vals[i] = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom_range(1, 255));
            end
            n = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 255));
            @(negedge clk);
            ready = 1'($urandom_range(0, 1));
            issue(n, 1'b1);
            wait_valid();
            finish_req($urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        #2;
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
